// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the five-stage pipeline. It shadows the A/T information
// of instructions in E/M/W and interlocks the multi-cycle multiply/divide unit.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RA1_D,
  input  logic [4:0] RA2_D,
  input  logic [4:0] WA_D,
  input  logic [1:0] Tuse_RA1,
  input  logic [1:0] Tuse_RA2,
  input  logic [1:0] Tnew_D,
  input  logic       md_start_D,
  input  logic       md_is_div_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic [1:0] fwd_rt_M,
  output logic       md_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [4:0] ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa_e_q, wa_e_d;
  logic [1:0] tnew_e_q, tnew_e_d;
  logic       md_start_e_q, md_start_e_d, md_is_div_e_q, md_is_div_e_d;
  logic [4:0] ra2_m_q, ra2_m_d, wa_m_q, wa_m_d;
  logic [1:0] tnew_m_q, tnew_m_d;
  logic [4:0] wa_w_q, wa_w_d;
  logic [3:0] busy_cnt_q, busy_cnt_d;
  logic       stall_rs_s, stall_rt_s, stall_md_s, stall_s;

  // Stall decision: a producer still in flight that cannot be ready by first use.
  always_comb begin
    stall_rs_s = (RA1_D != 5'd0) &&
                 (((RA1_D == wa_e_q) && (tnew_e_q > Tuse_RA1)) ||
                  ((RA1_D == wa_m_q) && (tnew_m_q > Tuse_RA1)));
    stall_rt_s = (RA2_D != 5'd0) &&
                 (((RA2_D == wa_e_q) && (tnew_e_q > Tuse_RA2)) ||
                  ((RA2_D == wa_m_q) && (tnew_m_q > Tuse_RA2)));
    stall_md_s = md_use_D && (md_start_e_q || (busy_cnt_q != 4'd0));
    stall_s    = stall_rs_s || stall_rt_s || stall_md_s;
  end

  // Forward selects: nearest matching producer wins; a not-yet-ready match yields 0.
  always_comb begin
    fwd_rs_D = 2'd0;
    fwd_rt_D = 2'd0;
    fwd_rs_E = 2'd0;
    fwd_rt_E = 2'd0;
    fwd_rt_M = 2'd0;
    if (RA1_D == 5'd0)             fwd_rs_D = 2'd0;
    else if (RA1_D == wa_e_q)      fwd_rs_D = (tnew_e_q == 2'd0) ? 2'd1 : 2'd0;
    else if (RA1_D == wa_m_q)      fwd_rs_D = (tnew_m_q == 2'd0) ? 2'd2 : 2'd0;
    else if (RA1_D == wa_w_q)      fwd_rs_D = 2'd3;
    else                           fwd_rs_D = 2'd0;
    if (RA2_D == 5'd0)             fwd_rt_D = 2'd0;
    else if (RA2_D == wa_e_q)      fwd_rt_D = (tnew_e_q == 2'd0) ? 2'd1 : 2'd0;
    else if (RA2_D == wa_m_q)      fwd_rt_D = (tnew_m_q == 2'd0) ? 2'd2 : 2'd0;
    else if (RA2_D == wa_w_q)      fwd_rt_D = 2'd3;
    else                           fwd_rt_D = 2'd0;
    if (ra1_e_q == 5'd0)           fwd_rs_E = 2'd0;
    else if (ra1_e_q == wa_m_q)    fwd_rs_E = (tnew_m_q == 2'd0) ? 2'd2 : 2'd0;
    else if (ra1_e_q == wa_w_q)    fwd_rs_E = 2'd3;
    else                           fwd_rs_E = 2'd0;
    if (ra2_e_q == 5'd0)           fwd_rt_E = 2'd0;
    else if (ra2_e_q == wa_m_q)    fwd_rt_E = (tnew_m_q == 2'd0) ? 2'd2 : 2'd0;
    else if (ra2_e_q == wa_w_q)    fwd_rt_E = 2'd3;
    else                           fwd_rt_E = 2'd0;
    if ((ra2_m_q != 5'd0) && (ra2_m_q == wa_w_q)) fwd_rt_M = 2'd3;
    else                                          fwd_rt_M = 2'd0;
  end

  // Next-state for the shadow pipeline and the multiply/divide busy counter.
  always_comb begin
    ra1_e_d       = 5'd0;
    ra2_e_d       = 5'd0;
    wa_e_d        = 5'd0;
    tnew_e_d      = 2'd0;
    md_start_e_d  = 1'b0;
    md_is_div_e_d = 1'b0;
    if (stall_s) begin
      ra1_e_d = 5'd0;
    end else begin
      ra1_e_d       = RA1_D;
      ra2_e_d       = RA2_D;
      wa_e_d        = WA_D;
      tnew_e_d      = Tnew_D;
      md_start_e_d  = md_start_D;
      md_is_div_e_d = md_is_div_D;
    end
    ra2_m_d  = ra2_e_q;
    wa_m_d   = wa_e_q;
    tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : (tnew_e_q - 2'd1);
    wa_w_d   = wa_m_q;
    if (md_start_e_q)                busy_cnt_d = md_is_div_e_q ? DIV_LOAD : MULT_LOAD;
    else if (busy_cnt_q != 4'd0)     busy_cnt_d = busy_cnt_q - 4'd1;
    else                             busy_cnt_d = busy_cnt_q;
  end

  // State registers; reset clears everything, including a divide in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra1_e_q       <= 5'd0;
      ra2_e_q       <= 5'd0;
      wa_e_q        <= 5'd0;
      tnew_e_q      <= 2'd0;
      md_start_e_q  <= 1'b0;
      md_is_div_e_q <= 1'b0;
      ra2_m_q       <= 5'd0;
      wa_m_q        <= 5'd0;
      tnew_m_q      <= 2'd0;
      wa_w_q        <= 5'd0;
      busy_cnt_q    <= 4'd0;
    end else begin
      ra1_e_q       <= ra1_e_d;
      ra2_e_q       <= ra2_e_d;
      wa_e_q        <= wa_e_d;
      tnew_e_q      <= tnew_e_d;
      md_start_e_q  <= md_start_e_d;
      md_is_div_e_q <= md_is_div_e_d;
      ra2_m_q       <= ra2_m_d;
      wa_m_q        <= wa_m_d;
      tnew_m_q      <= tnew_m_d;
      wa_w_q        <= wa_w_d;
      busy_cnt_q    <= busy_cnt_d;
    end
  end

  assign stall   = stall_s;
  assign md_busy = (busy_cnt_q != 4'd0);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction pairs with hand-derived stall/forward values.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] RA1_D = 5'd0, RA2_D = 5'd0, WA_D = 5'd0;
  logic [1:0] Tuse_RA1 = 2'd0, Tuse_RA2 = 2'd0, Tnew_D = 2'd0;
  logic       md_start_D = 1'b0, md_is_div_D = 1'b0, md_use_D = 1'b0;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
  int checks = 0;
  int failures = 0;
  int stall_cycles;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .RA1_D(RA1_D), .RA2_D(RA2_D), .WA_D(WA_D),
    .Tuse_RA1(Tuse_RA1), .Tuse_RA2(Tuse_RA2), .Tnew_D(Tnew_D),
    .md_start_D(md_start_D), .md_is_div_D(md_is_div_D), .md_use_D(md_use_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a D-stage instruction and let the combinational outputs settle.
  task automatic set_d(input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa,
                       input logic [1:0] tu1, input logic [1:0] tu2, input logic [1:0] tn,
                       input logic mds, input logic mdd, input logic mdu);
    RA1_D = ra1; RA2_D = ra2; WA_D = wa;
    Tuse_RA1 = tu1; Tuse_RA2 = tu2; Tnew_D = tn;
    md_start_D = mds; md_is_div_D = mdd; md_use_D = mdu;
    #1;
  endtask

  task automatic flush();
    set_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #2;
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_busy", {31'd0, md_busy}, 32'd0);
    check_val("rst_fwd", {22'd0, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}, 32'd0);
    #11 reset = 1'b1;
    tick();

    // load-use: lw $1 then add $2,$1,$1
    set_d(5'd20, 5'd0, 5'd1, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    check_val("lw_nostall", {31'd0, stall}, 32'd0);
    tick();
    set_d(5'd1, 5'd1, 5'd2, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    check_val("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    check_val("lu_release", {31'd0, stall}, 32'd0);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("lu_fwd_rs_E", {30'd0, fwd_rs_E}, 32'd3);
    check_val("lu_fwd_rt_E", {30'd0, fwd_rt_E}, 32'd3);
    flush();

    // branch after ALU: addu $3 then beq $3,$0
    set_d(5'd5, 5'd6, 5'd3, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd3, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("br_stall", {31'd0, stall}, 32'd1);
    tick();
    check_val("br_release", {31'd0, stall}, 32'd0);
    check_val("br_fwd_rs_D", {30'd0, fwd_rs_D}, 32'd2);
    check_val("br_fwd_rt_D", {30'd0, fwd_rt_D}, 32'd0);
    flush();

    // back-to-back ALU: addu $4; subu $5,$4,$4
    set_d(5'd7, 5'd8, 5'd4, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd4, 5'd4, 5'd5, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    check_val("alu_nostall", {31'd0, stall}, 32'd0);
    check_val("alu_fwd_D_notready", {30'd0, fwd_rs_D}, 32'd0);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("alu_fwd_rs_E", {30'd0, fwd_rs_E}, 32'd2);
    check_val("alu_fwd_rt_E", {30'd0, fwd_rt_E}, 32'd2);
    flush();

    // jal then jr $31
    set_d(5'd0, 5'd0, 5'd31, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd31, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("jr_nostall", {31'd0, stall}, 32'd0);
    check_val("jr_fwd_rs_D", {30'd0, fwd_rs_D}, 32'd1);
    flush();

    // addu $9 then sw $9: store data from W while sw is in M
    set_d(5'd7, 5'd8, 5'd9, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd10, 5'd9, 5'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("sw_nostall", {31'd0, stall}, 32'd0);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("sw_fwd_rt_E", {30'd0, fwd_rt_E}, 32'd2);
    tick();
    check_val("sw_fwd_rt_M", {30'd0, fwd_rt_M}, 32'd3);
    flush();

    // mult then mflo: 6 stall cycles
    set_d(5'd11, 5'd12, 5'd0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1);
    check_val("mult_nostall", {31'd0, stall}, 32'd0);
    tick();
    set_d(5'd0, 5'd0, 5'd13, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    check_val("mflo_busy0", {31'd0, md_busy}, 32'd0);
    stall_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (stall) begin
        stall_cycles++;
        tick();
      end else begin
        break;
      end
    end
    check_val("mult_stall_cycles", stall_cycles, 32'd6);
    check_val("mult_busy_done", {31'd0, md_busy}, 32'd0);
    flush();

    // div, reset asynchronously when the counter reads 7
    set_d(5'd11, 5'd12, 5'd0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    set_d(5'd0, 5'd0, 5'd13, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    check_val("div_busy", {31'd0, md_busy}, 32'd1);
    check_val("div_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    #1;
    check_val("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    check_val("rst_mid_stall", {31'd0, stall}, 32'd0);
    #1 reset = 1'b1;
    tick();
    check_val("post_rst_stall", {31'd0, stall}, 32'd0);
    flush();

    // writes to $0 with $0 consumers
    set_d(5'd20, 5'd0, 5'd0, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    check_val("zero_stall", {31'd0, stall}, 32'd0);
    check_val("zero_fwd_D", {28'd0, fwd_rs_D, fwd_rt_D}, 32'd0);
    tick();
    check_val("zero_fwd_E", {28'd0, fwd_rs_E, fwd_rt_E}, 32'd0);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/forward controller for the five-stage MIPS pipeline (F/D/E/M/W).
- Consumes per-instruction register addresses and Tuse/Tnew from the D-stage A/T decode.
- Tracks the A/T of in-flight instructions in its own E/M/W shadow registers.
- Drives pipeline stall/bubble and all forwarding-mux selects, and interlocks the multi-cycle multiply/divide unit via an internal busy counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu enters E.
- DIV_CYCLES, 10, busy cycles after div/divu enters E.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- RA1_D  in  5  rs address of the D-stage instruction.
- RA2_D  in  5  rt address of the D-stage instruction; 0 when rt is not read.
- WA_D  in  5  destination address of the D-stage instruction; 0 when there is no GRF write.
- Tuse_RA1  in  2  stage of first rs use: 0=D, 1=E, 2=M.
- Tuse_RA2  in  2  stage of first rt use: 0=D, 1=E, 2=M.
- Tnew_D  in  2  cycles until the result is ready, counted from E entry (0/1/2).
- md_start_D  in  1  D-stage instruction is mult/multu/div/divu.
- md_is_div_D  in  1  qualifies md_start_D as a divide.
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- stall  out  1  hold PC and F/D register; insert a bubble into D/E.
- fwd_rs_D, fwd_rt_D  out  2  D-stage compare/jr operand selects.
- fwd_rs_E, fwd_rt_E  out  2  ALU/muldiv operand selects.
- fwd_rt_M  out  2  store-data select: 0=GRF/pipe value, 2=from M, 3=from W (1 unused).
- md_busy  out  1  multiply/divide unit busy counter is non-zero.

Behaviour:
- Forward select encoding: 0 = no forward; 1 = from E; 2 = from M; 3 = from W. Value 1 is legal only for the D-stage selects.
- Shadow registers: E holds {RA1,RA2,WA,Tnew,md_start,md_is_div}; M holds {RA2,WA,Tnew}; W holds {WA}. Each updates on every clk edge; there is no global enable.
- D→E transfer: if stall=1, E loads a bubble (all fields zero); otherwise E loads the D inputs.
- E→M and M→W transfer: always. Tnew_M <= (Tnew_E==0) ? 0 : Tnew_E-1. W results are always ready.
- Stall term for rs: RA1_D != 0 and either
  - RA1_D == WA_E and Tnew_E > Tuse_RA1, or
  - RA1_D == WA_M and Tnew_M > Tuse_RA1.
- Stall term for rt: identical with RA2_D and Tuse_RA2.
- Muldiv stall: md_use_D and (md_start_E or md_busy).
- stall = rs term OR rt term OR muldiv stall. Purely combinational from inputs and state, same cycle.
- Busy counter (4 bits):
  - md_start_E at an edge: load DIV_CYCLES if md_is_div_E, else MULT_CYCLES.
  - Else if non-zero: decrement by 1.
  - md_busy = (counter != 0).
- Forward rule: address 0 never forwards. For each select, pick the nearest stage whose WA equals the consumer's register address and whose Tnew is 0:
  - D-stage selects: E, then M, then W.
  - E-stage selects: M, then W; compared against RA1_E/RA2_E.
  - fwd_rt_M: W only, compared against RA2_M.
  - If the nearest matching stage has Tnew != 0, that select is 0. Stall covers this case.
- Simultaneous events: the muldiv stall and a data stall may coincide; a single stall results with one bubble per cycle.
- Reset: reset=0 at any time clears all shadow registers and the busy counter immediately, including mid-divide. Resulting outputs: stall=0, all fwd_*=0, md_busy=0. The first edge after release operates normally.

Test Plan:
- Load-use: lw $1 (Tnew=2) then add $2,$1,$1 (Tuse 1/1) -> stall=1 for exactly 1 cycle; when add is in E, fwd_rs_E=fwd_rt_E=3.
- Branch after ALU: addu $3 then beq $3,$0 (Tuse=0) -> stall 1 cycle; next cycle fwd_rs_D=2, fwd_rt_D=0.
- Back-to-back ALU: addu $4; subu $5,$4,$4 -> no stall; when subu is in E, fwd_rs_E=fwd_rt_E=2.
- jal then jr $31 -> stall=0; fwd_rs_D=1 while jal is in E (Tnew=0).
- mult (MULT_CYCLES=5) immediately followed by mflo -> stall asserted 6 consecutive cycles (start in E plus counter 5..1); mflo enters E when the counter reaches 0.
- Reset mid-div (counter=7) -> md_busy=0 and stall=0 asynchronously. Writes to $0 with a $0 consumer -> never stall, never forward.
